extmem_arb: RTL and testbench
=============================

EXTMEM_ARB -- requirements
Module: extmem_arb

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles extmemenab stays high per access; legal range 1..15.
REQ-002 SHALL have port CLOCK, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port a_req, input, 1: port A (Unibus memory engine) access request, level.
REQ-005 SHALL have ports a_addr input 17 (word address), a_wdata input 18 (write data), a_wena input 2 (byte write enables; 00 = read).
REQ-006 SHALL have ports a_ack output 1 (one-cycle completion pulse) and a_rdata output 18 (read data).
REQ-007 SHALL have port group b_req, b_addr, b_wdata, b_wena, b_ack, b_rdata, same widths and meanings as port A; port B is the ARM side.
REQ-008 SHALL have port extmemaddr, output, 17: external memory word address.
REQ-009 SHALL have port extmemdout, output, 18: external memory write data.
REQ-010 SHALL have port extmemdin, input, 18: external memory read data.
REQ-011 SHALL have port extmemenab, output, 1: external memory enable.
REQ-012 SHALL have port extmemwena, output, 2: external memory byte write enables.
REQ-013 SHALL have port busy, output, 1: high while in GRANT.
REQ-014 SHALL have port lastb, output, 1: 1 when port B received the most recent grant.

Function
REQ-015 SHALL implement states IDLE and GRANT.
REQ-016 SHALL give each port an armed flag: cleared on that port's ack, set on any edge where that port's req is sampled low; a port is eligible only when req=1 and armed=1.
REQ-017 In IDLE with exactly one port eligible, SHALL grant that port on the next edge.
REQ-018 In IDLE with both ports eligible, SHALL grant the port not granted last (round-robin via lastb); after reset, port A wins the first tie.
REQ-019 On grant, SHALL register the port's addr onto extmemaddr, wdata onto extmemdout and wena onto extmemwena, set extmemenab=1 and lastb, load counter with LATENCY-1, and enter GRANT.
REQ-020 In GRANT, SHALL decrement the counter each cycle and hold extmemaddr, extmemdout and extmemwena stable.
REQ-021 In GRANT with counter=0, on the next edge SHALL:
  - drive extmemenab=0 and extmemwena=00;
  - pulse the granted port's ack for one cycle;
  - capture extmemdin into that port's rdata if its wena was 00 (else rdata unchanged);
  - return to IDLE.
  Net effect: extmemenab high for exactly LATENCY cycles.
REQ-022 Requests arriving during GRANT SHALL wait; arbitration occurs only in IDLE, so back-to-back accesses have one idle cycle between them.
REQ-023 Request inputs SHALL be sampled only at grant; changes to req, addr, wdata or wena during GRANT SHALL NOT affect the access in progress.
REQ-024 A port whose req stays high after its ack SHALL NOT be re-granted until req is sampled low for at least one edge.
REQ-025 rdata outputs SHALL hold their value until the next read completion on the same port.
REQ-026 At most one of a_ack or b_ack SHALL be high in any cycle.

Reset
REQ-027 RESET high SHALL immediately, without waiting for a clock edge, force:
  - state IDLE;
  - extmemenab=0 and extmemwena=00;
  - a_ack=b_ack=0;
  - busy=0 and lastb=0;
  - counter, extmemaddr, extmemdout, a_rdata and b_rdata to 0;
  - both armed flags to 1.
REQ-028 RESET asserted mid-access SHALL abandon the access with no ack; a req still high after reset release SHALL be granted as a fresh request.

Verification
REQ-029 A-only read, LATENCY=3: a_req=1, a_addr=0x00123, a_wena=00, extmemdin=0x2A5A5 -> extmemenab high 3 cycles, extmemaddr=0x00123, a_ack pulses once, a_rdata=0x2A5A5.
REQ-030 B-only write: b_wena=11, b_wdata=0x1FEFF -> extmemdout=0x1FEFF and extmemwena=11 during enab; b_ack pulses; b_rdata unchanged.
REQ-031 Both requesters continuously eligible, req dropped for one cycle after each ack -> grants alternate A,B,A,B; lastb toggles after each grant.
REQ-032 a_req held high 20 cycles after its ack -> no second grant; drop a_req one cycle and reassert -> granted again.
REQ-033 RESET pulsed in the 2nd GRANT cycle -> extmemenab=0 with no clock edge, no ack; after release with req still high -> a new full LATENCY-cycle access.
REQ-034 LATENCY=1 and LATENCY=15 with a single read each -> extmemenab high exactly 1 and 15 cycles respectively.

Source files
------------

// File: rtl/extmem_arb.sv
// extmem_arb: two-port arbiter in front of a single external memory.
// Port A (Unibus memory engine) and port B (ARM side) compete for the memory.
// Each access holds extmemenab high for LATENCY cycles and then acks the
// granted port. Ties alternate between the ports, and a port must drop its
// request for at least one edge before it can be granted again.
module extmem_arb #(
  parameter int LATENCY = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        a_req,
  input  logic [16:0] a_addr,
  input  logic [17:0] a_wdata,
  input  logic [1:0]  a_wena,
  output logic        a_ack,
  output logic [17:0] a_rdata,
  input  logic        b_req,
  input  logic [16:0] b_addr,
  input  logic [17:0] b_wdata,
  input  logic [1:0]  b_wena,
  output logic        b_ack,
  output logic [17:0] b_rdata,
  output logic [16:0] extmemaddr,
  output logic [17:0] extmemdout,
  input  logic [17:0] extmemdin,
  output logic        extmemenab,
  output logic [1:0]  extmemwena,
  output logic        busy,
  output logic        lastb
);

  localparam int ADDR_W = 17;
  localparam int DATA_W = 18;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                a_armed;
  logic                b_armed;
  logic                any_grant;
  logic                a_elig;
  logic                b_elig;
  logic                pick_b;
  logic                done;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_wena;

  // Eligibility and round-robin choice; A wins the first tie after reset
  // because any_grant is still clear.
  always_comb begin
    a_elig    = a_req & a_armed;
    b_elig    = b_req & b_armed;
    pick_b    = b_elig & (~a_elig | (any_grant & ~lastb));
    done      = (state == GRANT) && (cnt == 4'd0);
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_wena  = pick_b ? b_wena  : a_wena;
  end

  // Armed flags: a low request re-arms, the completing access disarms.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      a_armed <= 1'b1;
      b_armed <= 1'b1;
    end else begin
      if (!a_req)
        a_armed <= 1'b1;
      else if (done && !lastb)
        a_armed <= 1'b0;
      if (!b_req)
        b_armed <= 1'b1;
      else if (done && lastb)
        b_armed <= 1'b0;
    end
  end

  // Arbitration FSM with registered memory bus, acks and read data.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      any_grant  <= 1'b0;
      lastb      <= 1'b0;
      busy       <= 1'b0;
      extmemenab <= 1'b0;
      extmemwena <= 2'b00;
      extmemaddr <= '0;
      extmemdout <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_elig || b_elig) begin
            state      <= GRANT;
            busy       <= 1'b1;
            any_grant  <= 1'b1;
            lastb      <= pick_b;
            cnt        <= CNT_INIT;
            extmemenab <= 1'b1;
            extmemaddr <= sel_addr;
            extmemdout <= sel_wdata;
            extmemwena <= sel_wena;
          end
        end
        GRANT: begin
          if (cnt == 4'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            extmemenab <= 1'b0;
            extmemwena <= 2'b00;
            if (lastb) begin
              b_ack <= 1'b1;
              if (extmemwena == 2'b00)
                b_rdata <= extmemdin;
            end else begin
              a_ack <= 1'b1;
              if (extmemwena == 2'b00)
                a_rdata <= extmemdin;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_arb.sv
// Testbench for extmem_arb: directed scenarios plus randomized request rounds
// checked against a transaction-level model of the arbitration rules.
module tb_extmem_arb;
  localparam int LAT = 3;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [16:0] a_addr = '0, b_addr = '0;
  logic [17:0] a_wdata = '0, b_wdata = '0;
  logic [1:0]  a_wena = '0, b_wena = '0;
  logic [17:0] extmemdin = '0;

  logic        a_ack, b_ack, extmemenab, busy, lastb;
  logic [17:0] a_rdata, b_rdata, extmemdout;
  logic [16:0] extmemaddr;
  logic [1:0]  extmemwena;

  logic        a_ack_1, b_ack_1, enab_1, busy_1, lastb_1;
  logic [17:0] a_rdata_1, b_rdata_1, dout_1;
  logic [16:0] addr_1;
  logic [1:0]  wena_1;

  logic        a_ack_15, b_ack_15, enab_15, busy_15, lastb_15;
  logic [17:0] a_rdata_15, b_rdata_15, dout_15;
  logic [16:0] addr_15;
  logic [1:0]  wena_15;

  int n_cmp = 0;
  int n_bad = 0;
  int proto_bad = 0;
  bit restore_a = 0, restore_b = 0;
  logic prev_a = 0, prev_b = 0;

  // Reference model state
  logic [17:0] m_rd [2];
  bit m_lastb;
  bit m_fresh;

  always #5 CLOCK = ~CLOCK;

  extmem_arb #(.LATENCY(LAT)) u_l3 (
    .CLOCK(CLOCK), .RESET(RESET),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wena(a_wena),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wena(b_wena),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .extmemaddr(extmemaddr), .extmemdout(extmemdout), .extmemdin(extmemdin),
    .extmemenab(extmemenab), .extmemwena(extmemwena), .busy(busy), .lastb(lastb));

  extmem_arb #(.LATENCY(1)) u_l1 (
    .CLOCK(CLOCK), .RESET(RESET),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wena(a_wena),
    .a_ack(a_ack_1), .a_rdata(a_rdata_1),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wena(b_wena),
    .b_ack(b_ack_1), .b_rdata(b_rdata_1),
    .extmemaddr(addr_1), .extmemdout(dout_1), .extmemdin(extmemdin),
    .extmemenab(enab_1), .extmemwena(wena_1), .busy(busy_1), .lastb(lastb_1));

  extmem_arb #(.LATENCY(15)) u_l15 (
    .CLOCK(CLOCK), .RESET(RESET),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wena(a_wena),
    .a_ack(a_ack_15), .a_rdata(a_rdata_15),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wena(b_wena),
    .b_ack(b_ack_15), .b_rdata(b_rdata_15),
    .extmemaddr(addr_15), .extmemdout(dout_15), .extmemdin(extmemdin),
    .extmemenab(enab_15), .extmemwena(wena_15), .busy(busy_15), .lastb(lastb_15));

  // Ack protocol watch: never both acks, never an ack longer than one cycle.
  always @(negedge CLOCK) begin
    if (a_ack && b_ack) proto_bad++;
    if ((a_ack && prev_a) || (b_ack && prev_b)) proto_bad++;
    prev_a = a_ack;
    prev_b = b_ack;
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic model_reset();
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_lastb = 1'b0;
    m_fresh = 1'b1;
  endtask

  // Tie rule: the port not granted last wins; A wins before any grant.
  function automatic bit tie_winner();
    return (m_fresh || m_lastb) ? 1'b0 : 1'b1;
  endfunction

  // Wait for port p's access, check the bus and completion against the model.
  task automatic serve(input bit p, input bit drop, input bit restore, input logic [17:0] din);
    logic [16:0] ea;
    logic [17:0] ed;
    logic [1:0]  ew;
    bit got;
    int n;
    ea = p ? b_addr  : a_addr;
    ed = p ? b_wdata : a_wdata;
    ew = p ? b_wena  : a_wena;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (restore_a) begin a_req = 1'b1; restore_a = 0; end
      if (restore_b) begin b_req = 1'b1; restore_b = 0; end
      if (extmemenab) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL grant_timeout port=%0d: enab got 0 want 1", p);
      return;
    end
    n_cmp++;
    if (lastb !== p || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL grant_port: lastb/busy got %b%b want %b1", lastb, busy, p);
    end
    m_lastb = p;
    m_fresh = 0;
    extmemdin = din;
    // Inputs change mid-access; the access must keep its sampled values.
    if (p) begin
      b_addr = 17'($urandom); b_wdata = 18'($urandom); b_wena = 2'($urandom);
    end else begin
      a_addr = 17'($urandom); a_wdata = 18'($urandom); a_wena = 2'($urandom);
    end
    n = 0;
    while (extmemenab && n < 20) begin
      n++;
      n_cmp++;
      if ({extmemaddr, extmemdout, extmemwena} !== {ea, ed, ew}) begin
        n_bad++;
        $display("FAIL bus cyc%0d: got %h/%h/%b want %h/%h/%b", n,
                 extmemaddr, extmemdout, extmemwena, ea, ed, ew);
      end
      step();
    end
    n_cmp++;
    if (n != LAT) begin
      n_bad++;
      $display("FAIL enab_len: got %0d want %0d", n, LAT);
    end
    n_cmp++;
    if ({a_ack, b_ack} !== (p ? 2'b01 : 2'b10)) begin
      n_bad++;
      $display("FAIL ack: a/b got %b%b want %b", a_ack, b_ack, (p ? 2'b01 : 2'b10));
    end
    n_cmp++;
    if (extmemwena !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL release: wena/busy got %b/%b want 00/0", extmemwena, busy);
    end
    if (ew == 2'b00) m_rd[p] = din;
    n_cmp++;
    if (a_rdata !== m_rd[0] || b_rdata !== m_rd[1]) begin
      n_bad++;
      $display("FAIL rdata: got %h/%h want %h/%h", a_rdata, b_rdata, m_rd[0], m_rd[1]);
    end
    if (drop) begin
      if (p) b_req = 1'b0; else a_req = 1'b0;
      if (restore) begin
        if (p) restore_b = 1; else restore_a = 1;
      end
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if ({extmemenab, extmemwena, a_ack, b_ack, busy, lastb, extmemaddr,
         extmemdout, a_rdata, b_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: enab=%b wena=%b ack=%b%b busy=%b lastb=%b addr=%h want all 0",
               extmemenab, extmemwena, a_ack, b_ack, busy, lastb, extmemaddr);
    end
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_a_read();
    a_addr = 17'h00123; a_wena = 2'b00; a_wdata = 18'($urandom); a_req = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 18'h2A5A5);
    n_cmp++;
    if (a_rdata !== 18'h2A5A5) begin
      n_bad++;
      $display("FAIL a_read_data: got %h want 2a5a5", a_rdata);
    end
    step();
  endtask

  task automatic test_b_write();
    b_addr = 17'($urandom); b_wdata = 18'h1FEFF; b_wena = 2'b11; b_req = 1'b1;
    serve(1'b1, 1'b1, 1'b0, 18'h3FFFF);
    n_cmp++;
    if (b_rdata !== 18'h0) begin
      n_bad++;
      $display("FAIL b_write_rdata: got %h want 0", b_rdata);
    end
    step();
  endtask

  task automatic test_round_robin();
    bit p;
    a_addr = 17'($urandom); a_wdata = 18'($urandom); a_wena = 2'($urandom);
    b_addr = 17'($urandom); b_wdata = 18'($urandom); b_wena = 2'($urandom);
    a_req = 1'b1; b_req = 1'b1;
    p = tie_winner();
    for (int k = 0; k < 6; k++) begin
      serve(p, 1'b1, 1'b1, 18'($urandom));
      p = ~p;
    end
    a_req = 1'b0; b_req = 1'b0; restore_a = 0; restore_b = 0;
    step();
    step();
  endtask

  task automatic test_rearm();
    int g;
    a_addr = 17'($urandom); a_wdata = 18'($urandom); a_wena = 2'b00; a_req = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 18'($urandom));
    g = 0;
    repeat (20) begin
      step();
      if (extmemenab) g++;
    end
    n_cmp++;
    if (g != 0) begin
      n_bad++;
      $display("FAIL rearm_hold: grant cycles got %0d want 0", g);
    end
    a_req = 1'b0;
    restore_a = 1;
    serve(1'b0, 1'b1, 1'b0, 18'($urandom));
    step();
  endtask

  task automatic test_random();
    int mask;
    bit w;
    for (int r = 0; r < 12; r++) begin
      mask = $urandom_range(1, 3);
      if (mask[0]) begin
        a_addr = 17'($urandom); a_wdata = 18'($urandom); a_wena = 2'($urandom); a_req = 1'b1;
      end
      if (mask[1]) begin
        b_addr = 17'($urandom); b_wdata = 18'($urandom); b_wena = 2'($urandom); b_req = 1'b1;
      end
      if (mask == 3) begin
        w = tie_winner();
        serve(w, 1'b1, 1'b0, 18'($urandom));
        serve(~w, 1'b1, 1'b0, 18'($urandom));
      end else begin
        serve(mask[1], 1'b1, 1'b0, 18'($urandom));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    a_addr = 17'($urandom); a_wdata = 18'($urandom); a_wena = 2'b00; a_req = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (extmemenab) got = 1;
    end
    step();
    b_addr = 17'($urandom); b_wdata = 18'($urandom); b_wena = 2'($urandom); b_req = 1'b1;
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if (!got || extmemenab !== 1'b0 || busy !== 1'b0 || a_ack !== 1'b0 || a_rdata !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_mid: started=%0d enab=%b busy=%b ack=%b rdata=%h want 1/0/0/0/0",
               got, extmemenab, busy, a_ack, a_rdata);
    end
    #1 RESET = 1'b0;
    model_reset();
    serve(tie_winner(), 1'b1, 1'b0, 18'($urandom));
    serve(1'b1, 1'b1, 1'b0, 18'($urandom));
    step();
  endtask

  task automatic test_latency();
    int e3, e1, e15, k3, k1, k15;
    logic [17:0] d;
    #2 RESET = 1'b1;
    #2 RESET = 1'b0;
    model_reset();
    d = 18'($urandom);
    extmemdin = d;
    a_addr = 17'($urandom); a_wena = 2'b00; a_req = 1'b1; b_req = 1'b0;
    e3 = 0; e1 = 0; e15 = 0; k3 = 0; k1 = 0; k15 = 0;
    repeat (22) begin
      step();
      e3 += int'(extmemenab); e1 += int'(enab_1); e15 += int'(enab_15);
      k3 += int'(a_ack); k1 += int'(a_ack_1); k15 += int'(a_ack_15);
    end
    n_cmp++;
    if (e1 != 1 || k1 != 1 || a_rdata_1 !== d) begin
      n_bad++;
      $display("FAIL lat1: enab=%0d acks=%0d rdata=%h want 1/1/%h", e1, k1, a_rdata_1, d);
    end
    n_cmp++;
    if (e15 != 15 || k15 != 1 || a_rdata_15 !== d) begin
      n_bad++;
      $display("FAIL lat15: enab=%0d acks=%0d rdata=%h want 15/1/%h", e15, k15, a_rdata_15, d);
    end
    n_cmp++;
    if (e3 != 3 || k3 != 1 || a_rdata !== d) begin
      n_bad++;
      $display("FAIL lat3: enab=%0d acks=%0d rdata=%h want 3/1/%h", e3, k3, a_rdata, d);
    end
    a_req = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_a_read();
    test_b_write();
    test_round_robin();
    test_rearm();
    test_random();
    test_reset_mid();
    test_latency();
    n_cmp++;
    if (proto_bad != 0) begin
      n_bad++;
      $display("FAIL ack_protocol: violations got %0d want 0", proto_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
